// File: rtl/cmsdk_apb_wdog_rst_ctrl_pkg.sv
// Shared definitions for the watchdog reset controller.
// Contents: APB word addresses (PADDR[11:2]), the software-reset and unlock
// keys, the RSTINFO bit positions and the reset FSM state type.
package cmsdk_wdog_rst_pkg;

  localparam logic [9:0] ADDR_RSTINFO = 10'h000;  // byte offset 0x000
  localparam logic [9:0] ADDR_RSTCTRL = 10'h001;  // byte offset 0x004
  localparam logic [9:0] ADDR_SWRST   = 10'h002;  // byte offset 0x008
  localparam logic [9:0] ADDR_LENGTH  = 10'h003;  // byte offset 0x00C
  localparam logic [9:0] ADDR_LOCK    = 10'h004;  // byte offset 0x010

  localparam logic [31:0] SWRST_KEY  = 32'h5FA0_0001;
  localparam logic [31:0] UNLOCK_KEY = 32'h1ACC_E551;

  localparam int INFO_WDOG   = 0;
  localparam int INFO_SYSREQ = 1;
  localparam int INFO_SW     = 2;
  localparam int INFO_POR    = 3;

  typedef enum logic {
    RUN    = 1'b0,
    ASSERT = 1'b1
  } rst_state_t;

endpackage

// File: rtl/cmsdk_apb_wdog_rst_ctrl_if.sv
// APB slave bus bundle for the watchdog reset controller.
// Signals: PSEL, PENABLE, PWRITE, PADDR[11:2], PWDATA (master -> slave),
//          PRDATA (slave -> master).
interface cmsdk_apb_wdog_rst_ctrl_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [11:2] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;

  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA);
  modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA);
endinterface

// File: rtl/cmsdk_apb_wdog_rst_ctrl_sync.sv
// Two-flop synchronizer for the watchdog reset request followed by a
// rising-edge detector, so a held-high request yields a single pulse.
// Ports:
//   PCLK, PRESETn : clock, async active-low reset (all flops reset to 0)
//   i_async       : asynchronous input level
//   o_rise        : one-cycle pulse on a synchronized 0->1 transition
module cmsdk_wdog_rst_sync (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/cmsdk_apb_wdog_rst_ctrl.sv
// Always-on reset controller behind the APB watchdog.
// Turns watchdog, CPU and key-protected software requests into a stretched,
// programmable-length active-low SYSRESETn and records every cause in
// RSTINFO, which only PRESETn clears.
// Ports:
//   PCLK, PRESETn : clock, async active-low power-on reset
//   apb           : APB slave (setup-phase writes / read capture)
//   WDOGRES       : watchdog request, asynchronous to PCLK
//   SYSRESETREQ   : CPU request, PCLK domain, level-sensitive
//   SYSRESETn     : registered system reset output
// Build option: ARM_WDOG_RSTCTRL_LOCK_EN adds the LOCK register at 0x010.
//
// state  | meaning
// RUN    | SYSRESETn high, waiting for an enabled trigger
// ASSERT | SYSRESETn low, counter runs down from LENGTH to 1
module cmsdk_apb_wdog_rst_ctrl
  import cmsdk_wdog_rst_pkg::*;
#(
  parameter int RST_LEN = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  cmsdk_apb_wdog_rst_ctrl_if.slave  apb,
  input  logic                      WDOGRES,
  input  logic                      SYSRESETREQ,
  output logic                      SYSRESETn
);

  localparam logic [7:0] LEN_INIT = 8'(RST_LEN);

  rst_state_t  r_state;
  logic [7:0]  r_cnt;
  logic        r_sysrst_n;
  logic [3:0]  r_info;
  logic [1:0]  r_ctrl;
  logic [7:0]  r_len;
  logic [31:0] r_prdata;

  logic        w_wdog_rise;
  logic        w_setup, w_wr, w_rd, w_unlocked;
  logic        w_wdog_trig, w_sysreq_trig, w_sw_trig, w_any_trig;
  logic [3:0]  w_set, w_clr;
  logic [7:0]  w_len_wdata;
  logic [31:0] w_rdata;

  cmsdk_wdog_rst_sync u_sync (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .i_async (WDOGRES),
    .o_rise  (w_wdog_rise)
  );

  assign w_setup = apb.PSEL & ~apb.PENABLE;
  assign w_wr    = w_setup & apb.PWRITE;
  assign w_rd    = w_setup & ~apb.PWRITE;

`ifdef ARM_WDOG_RSTCTRL_LOCK_EN
  logic r_lock;  // 1 = locked

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)
      r_lock <= 1'b0;
    else if (w_wr && apb.PADDR == ADDR_LOCK)
      r_lock <= (apb.PWDATA != UNLOCK_KEY);
  end

  assign w_unlocked = ~r_lock;
`else
  assign w_unlocked = 1'b1;
`endif

  assign w_wdog_trig   = w_wdog_rise & r_ctrl[0];
  assign w_sysreq_trig = SYSRESETREQ & r_ctrl[1];
  assign w_sw_trig     = w_wr & w_unlocked & (apb.PADDR == ADDR_SWRST) &
                         (apb.PWDATA == SWRST_KEY);
  assign w_any_trig    = w_wdog_trig | w_sysreq_trig | w_sw_trig;

  // A zero length would never terminate the down-count, so store 1 instead.
  assign w_len_wdata = (apb.PWDATA[7:0] == 8'd0) ? 8'd1 : apb.PWDATA[7:0];
  assign w_clr = (w_wr && apb.PADDR == ADDR_RSTINFO) ? apb.PWDATA[3:0] : 4'b0000;

  always_comb begin
    w_set              = 4'b0000;
    w_set[INFO_WDOG]   = w_wdog_trig;
    w_set[INFO_SYSREQ] = w_sysreq_trig;
    w_set[INFO_SW]     = w_sw_trig;
  end

  always_comb begin
    w_rdata = 32'h0;
    case (apb.PADDR)
      ADDR_RSTINFO: w_rdata = {28'h0, r_info};
      ADDR_RSTCTRL: w_rdata = {30'h0, r_ctrl};
      ADDR_LENGTH:  w_rdata = {24'h0, r_len};
`ifdef ARM_WDOG_RSTCTRL_LOCK_EN
      ADDR_LOCK:    w_rdata = {31'h0, r_lock};
`endif
      default:      w_rdata = 32'h0;
    endcase
  end

  // Set has priority over write-1-to-clear so a cause is never lost.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_info   <= 4'b1000;
      r_ctrl   <= 2'b11;
      r_len    <= LEN_INIT;
      r_prdata <= 32'h0;
    end else begin
      r_info <= (r_info & ~w_clr) | w_set;
      if (w_wr && w_unlocked && apb.PADDR == ADDR_RSTCTRL)
        r_ctrl <= apb.PWDATA[1:0];
      if (w_wr && w_unlocked && apb.PADDR == ADDR_LENGTH)
        r_len <= w_len_wdata;
      if (w_rd)
        r_prdata <= w_rdata;
    end
  end

  // Triggers seen in ASSERT are only recorded; the running pulse is untouched.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state    <= ASSERT;
      r_cnt      <= LEN_INIT;
      r_sysrst_n <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_any_trig) begin
            r_state    <= ASSERT;
            r_cnt      <= r_len;
            r_sysrst_n <= 1'b0;
          end
        end
        ASSERT: begin
          if (r_cnt <= 8'd1) begin
            r_state    <= RUN;
            r_sysrst_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_state    <= ASSERT;
          r_sysrst_n <= 1'b0;
        end
      endcase
    end
  end

  assign SYSRESETn  = r_sysrst_n;
  assign apb.PRDATA = r_prdata;

endmodule

// File: tb/tb_cmsdk_apb_wdog_rst_ctrl.sv
// Bench for cmsdk_apb_wdog_rst_ctrl: register table, directed corner-case
// sequences and a randomized phase, all checked against a cycle-indexed
// reference model (reset release edge = model_rel).
module tb_cmsdk_apb_wdog_rst_ctrl;

  localparam logic [11:0] A_INFO = 12'h000;
  localparam logic [11:0] A_CTRL = 12'h004;
  localparam logic [11:0] A_SW   = 12'h008;
  localparam logic [11:0] A_LEN  = 12'h00C;
  localparam logic [11:0] A_LOCK = 12'h010;
  localparam logic [31:0] K_SW   = 32'h5FA0_0001;
  localparam logic [31:0] K_UNL  = 32'h1ACC_E551;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  logic WDOGRES = 1'b0;
  logic SYSRESETREQ = 1'b0;
  logic SYSRESETn;

  always #5 PCLK = ~PCLK;

  cmsdk_apb_wdog_rst_ctrl_if apb_if ();

  cmsdk_apb_wdog_rst_ctrl #(.RST_LEN(16)) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .apb         (apb_if),
    .WDOGRES     (WDOGRES),
    .SYSRESETREQ (SYSRESETREQ),
    .SYSRESETn   (SYSRESETn)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state. The model counts edges since reset release (m_k)
  // and tracks the edge at which SYSRESETn next returns high (m_rel).
  logic [3:0]  m_info;
  logic [1:0]  m_ctrl;
  logic [7:0]  m_len;
  logic        m_lock;
  int          m_k, m_rel;
  logic [2:0]  wh;       // WDOGRES as seen before edges k-1, k-2, k-3
  logic [31:0] m_rdata;

  int   pulses, low_cnt;
  logic prev_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      A_INFO: return {28'h0, m_info};
      A_CTRL: return {30'h0, m_ctrl};
      A_LEN:  return {24'h0, m_len};
`ifdef ARM_WDOG_RSTCTRL_LOCK_EN
      A_LOCK: return {31'h0, m_lock};
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge(input logic w_in, input logic s_in, input logic sel,
                            input logic en, input logic wr, input logic [11:0] a,
                            input logic [31:0] d);
    logic wt, st, swt, unl, wok;
    logic [3:0] clr;
    m_k++;
    unl = 1'b1;
`ifdef ARM_WDOG_RSTCTRL_LOCK_EN
    unl = ~m_lock;
`endif
    wok = sel & ~en & wr;
    wt  = wh[1] & ~wh[2] & m_ctrl[0];
    st  = s_in & m_ctrl[1];
    swt = wok & unl & (a == A_SW) & (d == K_SW);
    if (sel && !en && !wr) m_rdata = model_read(a);
    if ((wt || st || swt) && (m_k - 1 >= m_rel)) m_rel = m_k + int'(m_len);
    clr = (wok && a == A_INFO) ? d[3:0] : 4'h0;
    m_info = (m_info & ~clr) | {1'b0, swt, st, wt};
    if (wok && unl && a == A_CTRL) m_ctrl = d[1:0];
    if (wok && unl && a == A_LEN) m_len = (d[7:0] == 8'd0) ? 8'd1 : d[7:0];
`ifdef ARM_WDOG_RSTCTRL_LOCK_EN
    if (wok && a == A_LOCK) m_lock = (d != K_UNL);
`endif
    wh = {wh[1:0], w_in};
  endtask

  task automatic step();
    logic w_in, s_in, sel, en, wr;
    logic [11:0] a;
    logic [31:0] d;
    w_in = WDOGRES; s_in = SYSRESETREQ;
    sel = apb_if.PSEL; en = apb_if.PENABLE; wr = apb_if.PWRITE;
    a = {apb_if.PADDR, 2'b00}; d = apb_if.PWDATA;
    @(posedge PCLK);
    model_edge(w_in, s_in, sel, en, wr, a, d);
    #1;
    check("sysresetn_model", {31'h0, SYSRESETn}, {31'h0, (m_k >= m_rel)});
    if (prev_n && !SYSRESETn) pulses++;
    if (!SYSRESETn) low_cnt++;
    prev_n = SYSRESETn;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_counts();
    pulses = 0;
    low_cnt = 0;
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    apb_if.PSEL = 1'b1; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b1;
    apb_if.PADDR = a[11:2]; apb_if.PWDATA = d;
    step();
    apb_if.PENABLE = 1'b1;
    step();
    apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
    apb_if.PSEL = 1'b1; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b0;
    apb_if.PADDR = a[11:2];
    step();
    d = apb_if.PRDATA;
    check("prdata_model", d, m_rdata);
    apb_if.PENABLE = 1'b1;
    step();
    apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0;
  endtask

  task automatic read_expect(input string name, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(a, d);
    check(name, d, exp);
  endtask

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int first_hi, first_lo;
    logic [31:0] rd;

    apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b0;
    apb_if.PADDR = '0; apb_if.PWDATA = '0;
    m_info = 4'b1000; m_ctrl = 2'b11; m_len = 8'd16; m_lock = 1'b0;
    m_k = 0; m_rel = 16; wh = 3'b000; m_rdata = 32'h0;
    prev_n = 1'b0;
    clear_counts();

    tbl[0]  = '{1'b1, A_CTRL, 32'h0000_0000, 32'h0};
    tbl[1]  = '{1'b0, A_CTRL, 32'h0,         32'h0};
    tbl[2]  = '{1'b1, A_CTRL, 32'hFFFF_FFFE, 32'h0};
    tbl[3]  = '{1'b0, A_CTRL, 32'h0,         32'h2};
    tbl[4]  = '{1'b1, A_CTRL, 32'h0000_0000, 32'h0};
    tbl[5]  = '{1'b1, A_LEN,  32'h0000_01AB, 32'h0};
    tbl[6]  = '{1'b0, A_LEN,  32'h0,         32'hAB};
    tbl[7]  = '{1'b1, A_LEN,  32'h0000_0000, 32'h0};
    tbl[8]  = '{1'b0, A_LEN,  32'h0,         32'h1};
    tbl[9]  = '{1'b0, A_SW,   32'h0,         32'h0};
    tbl[10] = '{1'b1, 12'h014, 32'hFFFF_FFFF, 32'h0};
    tbl[11] = '{1'b0, 12'h014, 32'h0,         32'h0};
    tbl[12] = '{1'b0, A_LOCK, 32'h0,         32'h0};
    tbl[13] = '{1'b1, A_LEN,  32'h0000_0005, 32'h0};
    tbl[14] = '{1'b1, A_CTRL, 32'h0000_0003, 32'h0};
    tbl[15] = '{1'b0, A_CTRL, 32'h0,         32'h3};

    #1;
    check("rst_sysresetn", {31'h0, SYSRESETn}, 32'h0);
    check("rst_prdata", apb_if.PRDATA, 32'h0);
    #20;
    @(negedge PCLK);
    PRESETn = 1'b1;

    // Power-on pulse: high again after exactly 16 edges.
    first_hi = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (SYSRESETn && first_hi == 0) first_hi = i;
    end
    check("por_len", first_hi, 16);
    read_expect("por_info", A_INFO, 32'h8);
    apb_write(A_INFO, 32'h8);
    read_expect("por_info_clr", A_INFO, 32'h0);

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr) apb_write(tbl[i].addr, tbl[i].data);
      else read_expect($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].exp);
    end

    // Held watchdog request: one pulse, 3 edges latency, LENGTH=5.
    clear_counts();
    first_lo = 0;
    WDOGRES = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      step();
      if (!SYSRESETn && first_lo == 0) first_lo = i;
    end
    WDOGRES = 1'b0;
    idle(10);
    check("wdog_latency", first_lo, 3);
    check("wdog_pulses", pulses, 1);
    check("wdog_width", low_cnt, 5);
    read_expect("wdog_info", A_INFO, 32'h1);
    apb_write(A_INFO, 32'h1);

    // Software reset key.
    clear_counts();
    apb_write(A_SW, 32'h0000_1234);
    idle(10);
    check("sw_badkey_pulses", pulses, 0);
    apb_write(A_SW, K_SW);
    idle(10);
    check("sw_pulses", pulses, 1);
    check("sw_width", low_cnt, 5);
    read_expect("sw_info", A_INFO, 32'h4);
    apb_write(A_INFO, 32'h4);
    apb_write(A_LEN, 32'h0);
    clear_counts();
    apb_write(A_SW, K_SW);
    idle(5);
    check("len0_width", low_cnt, 1);
    check("len0_pulses", pulses, 1);
    apb_write(A_INFO, 32'h4);

    // SYSRESETREQ gated by SYSREQ_EN.
    apb_write(A_LEN, 32'h5);
    apb_write(A_CTRL, 32'h1);
    SYSRESETREQ = 1'b1;
    clear_counts();
    idle(10);
    check("sreq_dis_pulses", pulses, 0);
    read_expect("sreq_dis_info", A_INFO, 32'h0);
    apb_write(A_CTRL, 32'h3);
    SYSRESETREQ = 1'b0;
    idle(10);
    check("sreq_pulses", pulses, 1);
    check("sreq_width", low_cnt, 5);
    read_expect("sreq_info", A_INFO, 32'h2);
    apb_write(A_INFO, 32'h2);

    // SYSRESETREQ during a watchdog pulse does not stretch it.
    apb_write(A_LEN, 32'h8);
    clear_counts();
    WDOGRES = 1'b1;
    idle(4);
    SYSRESETREQ = 1'b1;
    step();
    SYSRESETREQ = 1'b0;
    WDOGRES = 1'b0;
    idle(15);
    check("overlap_pulses", pulses, 1);
    check("overlap_width", low_cnt, 8);
    read_expect("overlap_info", A_INFO, 32'h3);

    // W1C of bit1 on the same edge as a new SYSREQ trigger: set wins.
    SYSRESETREQ = 1'b1;
    apb_if.PSEL = 1'b1; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b1;
    apb_if.PADDR = A_INFO[11:2]; apb_if.PWDATA = 32'h2;
    step();
    SYSRESETREQ = 1'b0;
    apb_if.PENABLE = 1'b1;
    step();
    apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b0;
    idle(12);
    read_expect("w1c_set_wins", A_INFO, 32'h3);
    apb_write(A_INFO, 32'hF);
    read_expect("info_all_clr", A_INFO, 32'h0);

`ifdef ARM_WDOG_RSTCTRL_LOCK_EN
    apb_write(A_LEN, 32'h5);
    apb_write(A_LOCK, 32'h0);
    apb_write(A_LEN, 32'h9);
    read_expect("locked_len", A_LEN, 32'h5);
    read_expect("lock_rd1", A_LOCK, 32'h1);
    clear_counts();
    apb_write(A_SW, K_SW);
    idle(6);
    check("locked_sw_pulses", pulses, 0);
    apb_write(A_LOCK, K_UNL);
    apb_write(A_LEN, 32'h9);
    read_expect("unlocked_len", A_LEN, 32'h9);
    read_expect("lock_rd0", A_LOCK, 32'h0);
`else
    read_expect("nolock_rd", A_LOCK, 32'h0);
`endif

    // Randomized traffic against the model.
    for (int it = 0; it < 600; it++) begin
      logic [11:0] a;
      if ($urandom_range(7) == 0) WDOGRES = ~WDOGRES;
      SYSRESETREQ = ($urandom_range(15) == 0);
      case ($urandom_range(9))
        0: apb_write(A_CTRL, $urandom_range(3));
        1: apb_write(A_LEN, $urandom_range(10));
        2: apb_write(A_SW, ($urandom_range(1) == 1) ? K_SW : $urandom);
        3: apb_write(A_INFO, $urandom);
        4, 5: begin
          a = 12'($urandom_range(5)) << 2;
          apb_read(a, rd);
        end
        6: apb_write(A_LOCK, ($urandom_range(1) == 1) ? K_UNL : $urandom);
        default: step();
      endcase
    end
    WDOGRES = 1'b0;
    SYSRESETREQ = 1'b0;
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cmsdk_apb_wdog_rst_ctrl.md
Name: cmsdk_apb_wdog_rst_ctrl

Overview:
- Always-on reset controller directly downstream of the APB watchdog.
- Consumes the watchdog's WDOGRES output (WDOGCLK domain) and the CPU's SYSRESETREQ; also accepts a key-protected software request.
- Generates a stretched, programmable-length active-low system reset, SYSRESETn.
- Records the cause of every reset in an APB-readable register that survives SYSRESETn; that register is cleared only by PRESETn.

Parameters:
- RST_LEN, 16: reset value of LENGTH, in PCLK cycles SYSRESETn is held low (1..255).

Ports:
- PCLK  in  1  APB / controller clock
- PRESETn  in  1  power-on reset, asynchronous, active-low
- PSEL  in  1  APB select
- PENABLE  in  1  APB enable
- PWRITE  in  1  APB write
- PADDR  in  10 [11:2]  APB word address
- PWDATA  in  32  APB write data
- PRDATA  out  32  APB read data, registered
- WDOGRES  in  1  watchdog reset request, asynchronous to PCLK
- SYSRESETREQ  in  1  CPU reset request, PCLK domain
- SYSRESETn  out  1  system reset, active-low, glitch-free register output

Behaviour:
- Reset: PRESETn, asynchronous, active-low; clock PCLK. During PRESETn low:
  - SYSRESETn=0, PRDATA=0.
  - state=ASSERT, counter=RST_LEN.
  - RSTINFO=4'b1000 (POR), RSTCTRL=2'b11, LENGTH=RST_LEN.
- APB writes and read captures take effect in the setup phase (PSEL & ~PENABLE). PRDATA is valid in the access phase. Unmapped addresses read 0; writes to them are ignored.
- Register map (byte offsets):
  - 0x000 RSTINFO, bits [3:0] = {POR, SW, SYSREQ, WDOG}. Write-1-to-clear.
  - 0x004 RSTCTRL, bits [1:0] = {SYSREQ_EN, WDOG_EN}. RW.
  - 0x008 SWRST. Write-only, reads 0. Writing 0x5FA0_0001 triggers a software reset; any other value is ignored.
  - 0x00C LENGTH, bits [7:0]. RW. A written value of 0 is treated as 1.
- WDOGRES path:
  - 2-flop synchronizer, then a third flop for rising-edge detection.
  - wdog_trig = sync_q & ~prev_q & WDOG_EN.
  - A held-high level triggers only once.
- sysreq_trig = SYSRESETREQ & SYSREQ_EN. This is level-sensitive, so it retriggers in RUN if SYSRESETREQ is still high.
- FSM, 2 states:
  - RUN: SYSRESETn=1. Any trigger moves to ASSERT on the next edge and loads counter=LENGTH (0→1).
  - ASSERT: SYSRESETn=0, counter decrements each cycle. At counter==1 the FSM goes to RUN, so SYSRESETn is low for exactly LENGTH cycles.
- Latency:
  - SYSRESETREQ high before edge N → SYSRESETn low after edge N.
  - WDOGRES high before edge N → SYSRESETn low after edge N+2.
- Status capture:
  - Each trigger sets its RSTINFO bit in the same cycle it is seen, in either state.
  - Triggers during ASSERT are recorded but do not extend or restart the pulse.
  - Simultaneous triggers set all of the corresponding bits.
  - If set and W1C hit the same bit in the same cycle, set wins.
- A LENGTH write during ASSERT affects only the next pulse.
- The APB interface stays fully functional while SYSRESETn is low.

Optional Feature:
- Macro: ARM_WDOG_RSTCTRL_LOCK_EN.
- Defined:
  - Adds LOCK at 0x010, reset value 0 (unlocked).
  - Writing 0x1ACCE551 unlocks; writing any other value locks. A read returns the lock bit.
  - While locked, writes to RSTCTRL, LENGTH and SWRST are ignored. RSTINFO W1C remains writable.
- Undefined:
  - No LOCK register; 0x010 reads 0.
  - All registers are always writable.

Decomposition:
- Package cmsdk_wdog_rst_pkg holds:
  - register offsets;
  - SWRST_KEY=32'h5FA0_0001 and UNLOCK_KEY=32'h1ACCE551;
  - RSTINFO bit indices;
  - the FSM state enum {RUN, ASSERT}.
- One sub-module: cmsdk_wdog_rst_sync, a 2-flop synchronizer plus rising-edge detector, reset by PRESETn to 0.

Test Plan:
- POR: release PRESETn → SYSRESETn low for 16 cycles then high; RSTINFO reads 0x8. Write 0x8 to RSTINFO → reads 0x0.
- WDOGRES held high for 50 cycles with LENGTH=5 → exactly one pulse, SYSRESETn low for 5 cycles starting 3 edges after WDOGRES rises; RSTINFO=0x1.
- Write SWRST with 0x1234 → no reset. Write SWRST with 0x5FA0_0001 → reset pulse; RSTINFO bit2 set. Write LENGTH=0 then trigger again → 1-cycle pulse.
- RSTCTRL=2'b01 with SYSRESETREQ high → no pulse, RSTINFO unchanged. Set SYSREQ_EN → pulse; RSTINFO bit1 set.
- SYSRESETREQ fires during an active WDOG pulse → pulse length unchanged; RSTINFO=0x3. W1C of bit1 in the same cycle as a new SYSREQ trigger → bit1 stays 1.
- With ARM_WDOG_RSTCTRL_LOCK_EN, write LOCK=0 then LENGTH=9 → LENGTH reads 0x5. Write LOCK=0x1ACCE551 then LENGTH=9 → reads 0x9, LOCK reads 0.
